stack_ctrl: RTL and testbench



---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_ram.sv | 26 ++
 rtl/stack_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared defaults, FSM state type and count-width helper
// for the operand stack controller.
package stack_pkg;

  localparam int DATA_W_D = 8;
  localparam int DEPTH_D  = 16;

  typedef enum logic {
    READY,
    REFILL
  } state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_ram.sv
// stack_ram: single-port spill RAM for the operand stack.
// Synchronous write, registered read, no reset.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int WORDS  = 14,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: TOS/NOS register pair over a spill RAM, with refill FSM.
// Define STACK_CTRL_ERR_EN for the err_clr port and sticky error flags.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = DEPTH_D
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
`ifdef STACK_CTRL_ERR_EN
  input  logic                     err_clr,
`endif
  output logic [DATA_W-1:0]        tos,
  output logic [DATA_W-1:0]        nos,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     empty,
  output logic                     full,
  output logic                     ready,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW    = cnt_w(DEPTH);
  localparam int WORDS = DEPTH - 2;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            r_state;
  state_e            w_state_nx;
  logic [DATA_W-1:0] r_tos;
  logic [DATA_W-1:0] r_nos;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] w_tos_nx;
  logic [DATA_W-1:0] w_nos_nx;
  logic [CW-1:0]     w_cnt_nx;
  logic [CW-1:0]     w_cnt_m2;
  logic [CW-1:0]     w_cnt_m3;
  logic              w_empty;
  logic              w_full;
  logic              w_we;
  logic              w_re;
  logic [AW-1:0]     w_addr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_ovf_set;
  logic              w_unf_set;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(DEPTH));
  assign w_cnt_m2 = r_cnt - CW'(2);
  assign w_cnt_m3 = r_cnt - CW'(3);

  stack_ram #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (r_nos),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= READY;
      r_tos   <= '0;
      r_nos   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tos   <= w_tos_nx;
      r_nos   <= w_nos_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_tos_nx   = r_tos;
    w_nos_nx   = r_nos;
    w_cnt_nx   = r_cnt;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_addr     = '0;
    w_ovf_set  = 1'b0;
    w_unf_set  = 1'b0;
    unique case (r_state)
      READY: begin
        if (push && pop && !w_empty) begin
          w_tos_nx = din;
        end else if (push && !w_full) begin
          // NOS spills to RAM only once there is a real entry below TOS
          if (r_cnt >= CW'(2)) begin
            w_we   = 1'b1;
            w_addr = w_cnt_m2[AW-1:0];
          end
          w_nos_nx = r_tos;
          w_tos_nx = din;
          w_cnt_nx = r_cnt + CW'(1);
        end else if (push) begin
          w_ovf_set = 1'b1;
        end else if (pop && !w_empty) begin
          w_tos_nx = r_nos;
          w_cnt_nx = r_cnt - CW'(1);
          if (r_cnt >= CW'(3)) begin
            w_re       = 1'b1;
            w_addr     = w_cnt_m3[AW-1:0];
            w_state_nx = REFILL;
          end else begin
            w_nos_nx = '0;
          end
          if (r_cnt == CW'(1)) w_tos_nx = '0;
        end else if (pop) begin
          w_unf_set = 1'b1;
        end
      end
      REFILL: begin
        w_nos_nx   = w_rdata;
        w_state_nx = READY;
      end
      default: w_state_nx = READY;
    endcase
  end

`ifdef STACK_CTRL_ERR_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_unf_set)    r_unf <= 1'b1;
      else if (err_clr) r_unf <= 1'b0;
    end
  end

  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  logic w_unused_err;
  assign w_unused_err = w_ovf_set | w_unf_set;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign tos   = r_tos;
  assign nos   = r_nos;
  assign count = r_cnt;
  assign empty = w_empty;
  assign full  = w_full;
  assign ready = (r_state == READY);

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed self-checking bench for stack_ctrl (DEPTH=16).
// Flag expectations follow STACK_CTRL_ERR_EN.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = '0;
  logic       err_clr = 1'b0;
  logic [7:0] tos;
  logic [7:0] nos;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       ready;
  logic       overflow;
  logic       underflow;

  int n_vec = 0;
  int n_bad = 0;

`ifdef STACK_CTRL_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  stack_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (din),
`ifdef STACK_CTRL_ERR_EN
    .err_clr   (err_clr),
`endif
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ready     (ready),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1;
    din  = d;
    tick();
    push = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    chk("rst_tos", tos, 0);
    chk("rst_nos", nos, 0);
    chk("rst_cnt", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", ready, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    do_push(8'h11);
    chk("p1_tos", tos, 8'h11);
    chk("p1_ready", ready, 1);
    do_push(8'h22);
    do_push(8'h33);
    chk("p3_tos", tos, 8'h33);
    chk("p3_nos", nos, 8'h22);
    chk("p3_cnt", count, 3);
    chk("p3_ready", ready, 1);

    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_tos", tos, 8'h22);
    chk("pop_cnt", count, 2);
    chk("pop_ready0", ready, 0);
    tick();
    chk("refill_ready", ready, 1);
    chk("refill_nos", nos, 8'h11);

    push = 1'b1;
    pop  = 1'b1;
    din  = 8'h5A;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    chk("repl_tos", tos, 8'h5A);
    chk("repl_cnt", count, 2);
    chk("repl_nos", nos, 8'h11);

    do_push(8'h44);
    chk("p44_cnt", count, 3);
    pop = 1'b1;
    tick();
    pop  = 1'b0;
    push = 1'b1;
    din  = 8'h77;
    chk("busy_ready", ready, 0);
    tick();
    push = 1'b0;
    chk("busy_cnt", count, 2);
    chk("busy_tos", tos, 8'h5A);
    chk("busy_nos", nos, 8'h11);
    chk("busy_ovf", overflow, 0);
    tick();
    chk("busy_cnt2", count, 2);

    do_reset();
    for (int i = 1; i <= 16; i++) do_push(8'(i));
    chk("full_flag", full, 1);
    chk("full_cnt", count, 16);
    chk("full_tos", tos, 16);
    chk("full_nos", nos, 15);
    do_push(8'h99);
    chk("ovf_tos", tos, 16);
    chk("ovf_cnt", count, 16);
    chk("ovf_flag", overflow, ERR);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    push = 1'b1;
    pop  = 1'b1;
    din  = 8'hAA;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    chk("frepl_tos", tos, 8'hAA);
    chk("frepl_cnt", count, 16);
    chk("frepl_ovf", overflow, 0);

    for (int k = 15; k >= 2; k--) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("drain_tos", tos, k);
      chk("drain_rdy", ready, 0);
      tick();
      chk("drain_nos", nos, k - 1);
    end
    chk("drain_cnt", count, 2);

    do_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("unf_cnt", count, 0);
    chk("unf_tos", tos, 0);
    chk("unf_flag", underflow, ERR);
    chk("unf_ready", ready, 1);
    push = 1'b1;
    pop  = 1'b1;
    din  = 8'h3C;
    tick();
    push = 1'b0;
    pop  = 1'b0;
    chk("epp_cnt", count, 1);
    chk("epp_tos", tos, 8'h3C);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop1_cnt", count, 0);
    chk("pop1_tos", tos, 0);
    chk("pop1_empty", empty, 1);

    do_reset();
    do_push(8'h01);
    do_push(8'h02);
    do_push(8'h03);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("rr_busy", ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_cnt", count, 0);
    chk("rr_ready", ready, 1);
    chk("rr_nos", nos, 0);
    tick();
    chk("rr_nos2", nos, 0);
    do_push(8'hA1);
    chk("rr_p_cnt", count, 1);
    chk("rr_p_tos", tos, 8'hA1);
    chk("rr_p_nos", nos, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
